// File: rtl/sreg_8b_piso.sv
// 8-bit parallel-in, serial-out shift register for serialising a byte onto a
// single-bit link. Bytes leave MSB first, with zeros filling in behind them.
module sreg_8b_piso (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       ld,
   input  logic [7:0] pin,
   output logic       sout
);

   logic [7:0] sreg_r;
   logic [7:0] sreg_nxt_s;

   // Next-state selection: a load overrides a shift, and with neither the register holds
   always_comb begin
      sreg_nxt_s = sreg_r;
      if (ld == 1'b1) begin
         sreg_nxt_s = pin;
      end else if (en == 1'b1) begin
         sreg_nxt_s = {sreg_r[6:0], 1'b0};
      end else begin
         sreg_nxt_s = sreg_r;
      end
   end

   // Shift register state, cleared asynchronously by the active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (reset == 1'b0) begin
         sreg_r <= 8'h00;
      end else begin
         sreg_r <= sreg_nxt_s;
      end
   end

   assign sout = sreg_r[7];

endmodule

// File: tb/tb_sreg_8b_piso.sv
// Self-checking bench for sreg_8b_piso: hand-computed vector table,
// directed reset sequences, and a random run against a reference model.
module tb_sreg_8b_piso;

   logic       clk;
   logic       reset;
   logic       en;
   logic       ld;
   logic [7:0] pin;
   logic       sout;

   int total;
   int bad;

   typedef struct {
      logic       ld;
      logic       en;
      logic [7:0] pin;
      logic       exp;
      string      name;
   } vec_t;

   vec_t vecs[$];

   sreg_8b_piso dut (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .ld    (ld),
      .pin   (pin),
      .sout  (sout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic l, input logic e, input logic [7:0] p,
                      input logic x, input string n);
      vec_t v;
      v.ld   = l;
      v.en   = e;
      v.pin  = p;
      v.exp  = x;
      v.name = n;
      vecs.push_back(v);
   endtask

   task automatic check(input string n, input logic act, input logic req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: sout=%b required=%b at %0t", n, act, req, $time);
      end
   endtask

   // Drive inputs, let one rising edge happen, then sample 1 time unit later
   task automatic step(input logic l, input logic e, input logic [7:0] p);
      ld  = l;
      en  = e;
      pin = p;
      @(posedge clk);
      #1;
   endtask

   logic [7:0] model;

   initial begin
      total = 0;
      bad   = 0;

      // Single load of 1101_0110 followed by 10 shifts and 2 idle cycles
      add(1'b1, 1'b0, 8'hD6, 1'b1, "single_load");
      add(1'b0, 1'b1, 8'h00, 1'b1, "single_sh1");
      add(1'b0, 1'b1, 8'h00, 1'b0, "single_sh2");
      add(1'b0, 1'b1, 8'h00, 1'b1, "single_sh3");
      add(1'b0, 1'b1, 8'h00, 1'b0, "single_sh4");
      add(1'b0, 1'b1, 8'h00, 1'b1, "single_sh5");
      add(1'b0, 1'b1, 8'h00, 1'b1, "single_sh6");
      add(1'b0, 1'b1, 8'h00, 1'b0, "single_sh7");
      add(1'b0, 1'b1, 8'h00, 1'b0, "single_sh8");
      add(1'b0, 1'b1, 8'h00, 1'b0, "single_sh9");
      add(1'b0, 1'b1, 8'h00, 1'b0, "single_sh10");
      add(1'b0, 1'b0, 8'hFF, 1'b0, "single_idle1");
      add(1'b0, 1'b0, 8'hFF, 1'b0, "single_idle2");
      // Reload mid-shift: 1100_1001, two shifts, then reload FF and nine shifts
      add(1'b1, 1'b0, 8'hC9, 1'b1, "reload_ld1");
      add(1'b0, 1'b1, 8'h00, 1'b1, "reload_sh1");
      add(1'b0, 1'b1, 8'h00, 1'b0, "reload_sh2");
      add(1'b1, 1'b0, 8'hFF, 1'b1, "reload_ld2");
      for (int k = 1; k <= 7; k++) add(1'b0, 1'b1, 8'h00, 1'b1, "reload_ff_sh");
      add(1'b0, 1'b1, 8'h00, 1'b0, "reload_ff_sh8");
      add(1'b0, 1'b1, 8'h00, 1'b0, "reload_ff_sh9");
      // Enable gating: FF loaded, then (2 shift, 2 hold) x5; pin toggles but ld=0
      add(1'b1, 1'b0, 8'hFF, 1'b1, "gate_ld");
      add(1'b0, 1'b1, 8'h3C, 1'b1, "gate_p1s1");
      add(1'b0, 1'b1, 8'h3C, 1'b1, "gate_p1s2");
      add(1'b0, 1'b0, 8'h3C, 1'b1, "gate_p1h1");
      add(1'b0, 1'b0, 8'h3C, 1'b1, "gate_p1h2");
      add(1'b0, 1'b1, 8'h3C, 1'b1, "gate_p2s1");
      add(1'b0, 1'b1, 8'h3C, 1'b1, "gate_p2s2");
      add(1'b0, 1'b0, 8'h3C, 1'b1, "gate_p2h1");
      add(1'b0, 1'b0, 8'h3C, 1'b1, "gate_p2h2");
      add(1'b0, 1'b1, 8'h3C, 1'b1, "gate_p3s1");
      add(1'b0, 1'b1, 8'h3C, 1'b1, "gate_p3s2");
      add(1'b0, 1'b0, 8'h3C, 1'b1, "gate_p3h1");
      add(1'b0, 1'b0, 8'h3C, 1'b1, "gate_p3h2");
      add(1'b0, 1'b1, 8'h3C, 1'b1, "gate_p4s1");
      add(1'b0, 1'b1, 8'h3C, 1'b0, "gate_p4s2");
      add(1'b0, 1'b0, 8'h3C, 1'b0, "gate_p4h1");
      add(1'b0, 1'b0, 8'h3C, 1'b0, "gate_p4h2");
      add(1'b0, 1'b1, 8'h3C, 1'b0, "gate_p5s1");
      add(1'b0, 1'b1, 8'h3C, 1'b0, "gate_p5s2");
      add(1'b0, 1'b0, 8'h3C, 1'b0, "gate_p5h1");
      add(1'b0, 1'b0, 8'h3C, 1'b0, "gate_p5h2");
      // Load/enable collision with A5: load wins, then 0,1,0,0,1,0,1,0
      add(1'b1, 1'b1, 8'hA5, 1'b1, "coll_ld");
      add(1'b0, 1'b1, 8'h00, 1'b0, "coll_sh1");
      add(1'b0, 1'b1, 8'h00, 1'b1, "coll_sh2");
      add(1'b0, 1'b1, 8'h00, 1'b0, "coll_sh3");
      add(1'b0, 1'b1, 8'h00, 1'b0, "coll_sh4");
      add(1'b0, 1'b1, 8'h00, 1'b1, "coll_sh5");
      add(1'b0, 1'b1, 8'h00, 1'b0, "coll_sh6");
      add(1'b0, 1'b1, 8'h00, 1'b1, "coll_sh7");
      add(1'b0, 1'b1, 8'h00, 1'b0, "coll_sh8");

      // Reset state, asserted from time zero with load requested
      reset = 1'b0;
      ld    = 1'b1;
      en    = 1'b1;
      pin   = 8'hFF;
      #1;
      check("reset_init", sout, 1'b0);
      @(posedge clk);
      #1;
      check("reset_hold_ld", sout, 1'b0);
      ld  = 1'b0;
      en  = 1'b0;
      #2;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("reset_release_idle", sout, 1'b0);

      foreach (vecs[i]) begin
         step(vecs[i].ld, vecs[i].en, vecs[i].pin);
         check(vecs[i].name, sout, vecs[i].exp);
      end

      // Reset mid-operation: load FF, shift 3, async reset, release, shift 3
      step(1'b1, 1'b0, 8'hFF);
      check("rst_mid_ld", sout, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b1, 8'h00);
         check("rst_mid_sh", sout, 1'b1);
      end
      en = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check("rst_async", sout, 1'b0);
      ld  = 1'b1;
      pin = 8'hFF;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check("rst_held", sout, 1'b0);
      end
      ld = 1'b0;
      #2;
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b1, 8'hFF);
         check("rst_post_sh", sout, 1'b0);
      end

      // Random run against a model of the load/shift/hold priority
      model = 8'h00;
      for (int k = 0; k < 50; k++) begin
         logic       r_ld;
         logic       r_en;
         logic [7:0] r_pin;
         r_ld  = ($urandom_range(0, 3) == 0);
         r_en  = 1'($urandom_range(0, 1));
         r_pin = 8'($urandom_range(0, 255));
         if (r_ld) model = r_pin;
         else if (r_en) model = {model[6:0], 1'b0};
         step(r_ld, r_en, r_pin);
         check("random", sout, model[7]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
